bcd_counter_n: RTL and testbench
================================

# bcd_counter_n

Parametrised N-digit BCD up/down counter. Successor to the two-digit counter, for the display and timekeeping paths. Adds:
- Generic digit count.
- Synchronous parallel load with per-digit sanitising.
- Terminal-count and wrap indications for cascading.
- Optional saturate mode in place of wrap-around.

Each digit is a 4-bit BCD nibble; digit 0 is least significant.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits (≥1); count width W = 4*DIGITS.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  count enable; one step per enabled cycle.
- up_down  in  1  1 = count up, 0 = count down.
- load  in  1  synchronous parallel load strobe.
- load_val  in  W  value to load; nibble i → digit i.
- sat  in  1  saturate-mode select (effective only with BCD_CNT_SAT_EN).
- count  out  W  registered counter value, nibble i = digit i.
- tc  out  1  terminal count, combinational from count and up_down.
- wrap  out  1  registered one-cycle pulse on wrap-around.
- load_err  out  1  registered one-cycle pulse: load_val contained a non-BCD nibble.

## Operation
- Priority per cycle: rst > load > en > hold.
- rst: count = 0, wrap = 0, load_err = 0.
- load:
  - Each nibble > 9 is clamped to 9; nibbles ≤ 9 are loaded unchanged.
  - load_err = 1 if any nibble was clamped, else 0.
  - wrap = 0. en is ignored that cycle.
- en, up (up_down = 1):
  - Digit 0 increments.
  - Digit i (i > 0) increments only when digits 0..i-1 are all 9.
  - Any digit stepping past 9 becomes 0.
  - All digits 9 → count = 0, wrap = 1.
- en, down (up_down = 0):
  - Digit 0 decrements.
  - Digit i (i > 0) decrements only when digits 0..i-1 are all 0.
  - Any digit stepping below 0 becomes 9.
  - All digits 0 → count = all-9s, wrap = 1.
- Idle (no rst, no load, no en): count holds; wrap = 0, load_err = 0.
- tc = 1 when:
  - up_down = 1 and count = all-9s, or
  - up_down = 0 and count = 0.
  - tc does not depend on en. Cascade convention: the next stage enables on en & tc.
- Digits never leave 0–9 through counting. After reset or load every digit is BCD-valid.
- up_down may change every cycle. Each enabled step uses the direction sampled on that edge.

## Timing
- count, wrap, load_err update on the rising clk edge where the condition is sampled. Latency is 1 cycle.
- wrap is high for exactly the one cycle in which count shows the wrapped value. It is 0 in every other cycle.
- load_err is high for exactly the one cycle following the load edge.
- tc is combinational. It is valid in the same cycle as count and up_down; there is no register stage.
- rst asserted mid-count or together with load/en: count = 0 on that edge; all pulses cleared.
- Back-to-back loads are allowed. Each load produces its own load_err value.

## Configuration
- Macro: BCD_CNT_SAT_EN.
- Defined:
  - With sat = 1, en at the terminal value holds count (all-9s going up, 0 going down).
  - wrap stays 0 in that case; tc remains asserted.
  - With sat = 0, behaviour is the wrap-around described above.
- Undefined:
  - sat is ignored (unconnected internally); the counter always wraps.
  - Port list is unchanged either way.

## Test plan
- Reset and increment: DIGITS=2, rst then en=1, up_down=1 for 100 cycles.
  - count steps 00→99, then 00.
  - wrap = 1 only in the cycle count = 00 after 99.
  - tc = 1 only while count = 99.
- Down-count borrow: DIGITS=4, load 0x1000, then en=1, up_down=0 for one cycle.
  - count = 0x0999, wrap = 0.
  - From 0x0000 one more down step gives 0x9999, wrap = 1.
- Load clamp: load_val = 0x3A7F.
  - count = 0x3979, load_err = 1 for one cycle.
  - load_val = 0x1234 gives load_err = 0.
- Priority: rst=1, load=1, en=1 in the same cycle.
  - count = 0.
  - Then load=1, en=1 with load_val = 0x0042: count = 0x0042, not 0x0043.
- Saturation (with BCD_CNT_SAT_EN), sat=1:
  - Count up from 0x9998 for three cycles: count = 0x9999 and holds, wrap never 1, tc = 1.
  - Same stimulus with sat=0: count = 0x0000 on the second step, wrap = 1.
- Direction change and hold:
  - From 0x0019, en up one cycle gives 0x0020.
  - Then en down one cycle gives 0x0019.
  - Then en=0 for 5 cycles: count holds 0x0019, wrap = 0.

Source files
------------

// File: rtl/bcd_counter_n.sv
// -----------------------------------------------------------------------------
// bcd_counter_n
//
// Parametrised N-digit BCD up/down counter with synchronous parallel load,
// per-digit load sanitising, terminal-count / wrap indications for cascading
// and an optional saturate mode.
//
// Digit i lives in count[4*i +: 4]; digit 0 is the least significant.
//
// Optional feature macro: BCD_CNT_SAT_EN
//   defined   : sat = 1 makes an enabled step at the terminal value hold the
//               count (all-9s going up, 0 going down) with wrap kept low.
//   undefined : sat is ignored and the counter always wraps around.
//   The port list is identical in both builds.
//
// Parameters:
//   DIGITS    number of BCD digits (>= 1); count width W = 4*DIGITS
//
// Ports:
//   clk       in   1  clock, all state updates on the rising edge
//   rst       in   1  synchronous, active-high reset
//   en        in   1  count enable, one step per enabled cycle
//   up_down   in   1  1 = count up, 0 = count down (sampled every step)
//   load      in   1  synchronous parallel load strobe (beats en)
//   load_val  in   W  value to load, nibble i -> digit i, clamped to 9
//   sat       in   1  saturate-mode select (only with BCD_CNT_SAT_EN)
//   count     out  W  registered counter value
//   tc        out  1  terminal count, combinational from count and up_down
//   wrap      out  1  registered one-cycle pulse while count shows a wrap
//   load_err  out  1  registered one-cycle pulse: last load had a non-BCD nibble
//
// Per-cycle priority: rst > load > en > hold.
// Cascading: the next stage should enable on (en & tc).
// -----------------------------------------------------------------------------
module bcd_counter_n #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up_down,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                sat,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                wrap,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  // Candidate next values for a step in each direction.
  logic [W-1:0] stepped_up;
  logic [W-1:0] stepped_down;
  logic [W-1:0] stepped;

  // Whole-counter terminal conditions.
  logic         all_nines;
  logic         all_zeros;
  logic         terminal;

  // Sanitised load value and its error flag.
  logic [W-1:0] load_clamped;
  logic         load_bad;

  // High when an enabled step must hold instead of wrapping.
  logic         sat_hold;

  // ---------------------------------------------------------------------------
  // Step logic. A digit moves only when every lower digit is at its rollover
  // value (9 going up, 0 going down); 'carry'/'borrow' ripple that condition
  // upward. After the last digit they tell whether the whole count is all-9s
  // or all-0s, which is exactly the terminal condition.
  // ---------------------------------------------------------------------------
  always_comb begin : step_logic
    logic       carry;
    logic       borrow;
    logic [3:0] d;
    carry        = 1'b1;
    borrow       = 1'b1;
    d            = 4'd0;
    stepped_up   = '0;
    stepped_down = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = count[4*i +: 4];

      if (!carry) begin
        stepped_up[4*i +: 4] = d;
      end else if (d == 4'd9) begin
        stepped_up[4*i +: 4] = 4'd0;
      end else begin
        stepped_up[4*i +: 4] = d + 4'd1;
      end

      if (!borrow) begin
        stepped_down[4*i +: 4] = d;
      end else if (d == 4'd0) begin
        stepped_down[4*i +: 4] = 4'd9;
      end else begin
        stepped_down[4*i +: 4] = d - 4'd1;
      end

      carry  = carry  & (d == 4'd9);
      borrow = borrow & (d == 4'd0);
    end
    all_nines = carry;
    all_zeros = borrow;
  end

  assign stepped  = up_down ? stepped_up : stepped_down;
  assign terminal = up_down ? all_nines : all_zeros;

  // tc has no register stage: it follows count and up_down directly so a
  // downstream stage sees it in the same cycle it would be enabled.
  assign tc = terminal;

  // ---------------------------------------------------------------------------
  // Load sanitising: every nibble above 9 is forced to 9 so the counter never
  // holds a non-BCD digit; any such nibble raises the error flag.
  // ---------------------------------------------------------------------------
  always_comb begin : load_sanitise
    logic [3:0] n;
    n            = 4'd0;
    load_clamped = '0;
    load_bad     = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      n = load_val[4*i +: 4];
      if (n > 4'd9) begin
        load_clamped[4*i +: 4] = 4'd9;
        load_bad               = 1'b1;
      end else begin
        load_clamped[4*i +: 4] = n;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Saturation. Only a step taken at the terminal value is affected; such a
  // step would otherwise wrap, so holding also suppresses the wrap pulse.
  // ---------------------------------------------------------------------------
`ifdef BCD_CNT_SAT_EN
  assign sat_hold = sat & terminal;
`else
  logic sat_unused;
  assign sat_unused = sat;
  assign sat_hold   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register. wrap and load_err are one-cycle pulses, so every branch
  // that does not raise them drives them low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      count    <= load_clamped;
      wrap     <= 1'b0;
      load_err <= load_bad;
    end else if (en) begin
      load_err <= 1'b0;
      if (sat_hold) begin
        wrap <= 1'b0;
      end else begin
        count <= stepped;
        // Stepping from the terminal value is by definition a wrap.
        wrap  <= terminal;
      end
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// -----------------------------------------------------------------------------
// tb_bcd_counter_n
//
// Bench for bcd_counter_n. Two instances share one stimulus stream: a 4-digit
// and a 2-digit counter (the 2-digit one sees the low byte of load_val).
// The reference model keeps each counter as a plain decimal integer modulo
// 10^DIGITS and converts it to BCD only for comparison. Directed sequences
// pin the model with literal values; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_bcd_counter_n;

  // ---------------------------------------------------------------------------
  // Clock / reset block
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      = 1'b1;
  logic        en       = 1'b0;
  logic        up_down  = 1'b1;
  logic        load     = 1'b0;
  logic        sat      = 1'b0;
  logic [15:0] load_val = 16'h0000;

  logic [15:0] count4;
  logic        tc4, wrap4, err4;
  logic [7:0]  count2;
  logic        tc2, wrap2, err2;

  bcd_counter_n #(.DIGITS(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_down  (up_down),
    .load     (load),
    .load_val (load_val),
    .sat      (sat),
    .count    (count4),
    .tc       (tc4),
    .wrap     (wrap4),
    .load_err (err4)
  );

  bcd_counter_n #(.DIGITS(2)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_down  (up_down),
    .load     (load),
    .load_val (load_val[7:0]),
    .sat      (sat),
    .count    (count2),
    .tc       (tc2),
    .wrap     (wrap2),
    .load_err (err2)
  );

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: decimal integers
  // ---------------------------------------------------------------------------
  int  v4 = 0, v2 = 0;
  bit  w4 = 0, w2 = 0, e4 = 0, e2 = 0;
  bit  model_valid = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  exp_q2[$];

  function automatic int pow10(input int d);
    int r;
    r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Decimal value of a load word after clamping each digit to 9.
  task automatic clamp_load(input logic [15:0] lv, input int digits, output int val, output bit err);
    int n;
    val = 0;
    err = 0;
    for (int i = digits - 1; i >= 0; i--) begin
      n = int'(lv[4*i +: 4]);
      if (n > 9) begin
        n   = 9;
        err = 1;
      end
      val = val * 10 + n;
    end
  endtask

  task automatic model_update(inout int v, inout bit w, inout bit er, input int digits,
                              input bit r, input bit l, input bit e_, input bit ud,
                              input logic [15:0] lv);
    int m, cv;
    bit ce, term, sat_mode;
    m = pow10(digits);
    sat_mode = 0;
`ifdef BCD_CNT_SAT_EN
    sat_mode = sat;
`endif
    if (r) begin
      v = 0; w = 0; er = 0;
    end else if (l) begin
      clamp_load(lv, digits, cv, ce);
      v = cv; er = ce; w = 0;
    end else if (e_) begin
      er   = 0;
      term = ud ? (v == m - 1) : (v == 0);
      if (sat_mode && term) begin
        w = 0;
      end else begin
        v = ud ? (v + 1) % m : (v + m - 1) % m;
        w = term;
      end
    end else begin
      w = 0; er = 0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: apply one cycle of inputs, advance model at the edge, return #1
  // after the edge so the caller can look at the registered outputs.
  // ---------------------------------------------------------------------------
  task automatic step(input bit r, input bit l, input logic [15:0] lv,
                      input bit e_, input bit ud, input bit s);
    rst = r; load = l; load_val = lv; en = e_; up_down = ud; sat = s;
    @(posedge clk);
    model_update(v4, w4, e4, 4, r, l, e_, ud, lv);
    model_update(v2, w2, e2, 2, r, l, e_, ud, lv);
    if (r) model_valid = 1;
    if (model_valid) begin
      exp_q.push_back(to_bcd(v4));
      exp_q2.push_back(to_bcd(v2)[7:0]);
    end
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard: every negedge compare both DUTs against the model.
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] e4c;
    logic [7:0]  e2c;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q2.size() > 0) begin
        e4c = exp_q.pop_front();
        e2c = exp_q2.pop_front();
        check("sb_count4", 32'(count4), 32'(e4c));
        check("sb_wrap4",  32'(wrap4),  32'(w4));
        check("sb_err4",   32'(err4),   32'(e4));
        check("sb_tc4",    32'(tc4),    32'(up_down ? (v4 == 9999) : (v4 == 0)));
        check("sb_count2", 32'(count2), 32'(e2c));
        check("sb_wrap2",  32'(wrap2),  32'(w2));
        check("sb_err2",   32'(err2),   32'(e2));
        check("sb_tc2",    32'(tc2),    32'(up_down ? (v2 == 99) : (v2 == 0)));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] lv;

    // Reset
    step(1, 0, 16'h0000, 0, 1, 0);
    step(1, 0, 16'h0000, 0, 1, 0);
    check("rst_count4", 32'(count4), 32'h0);
    check("rst_count2", 32'(count2), 32'h0);
    check("rst_wrap4",  32'(wrap4),  32'h0);
    check("rst_err4",   32'(err4),   32'h0);

    // Up count 100 steps: 2-digit counter goes 00..99 then wraps to 00.
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 16'h0000, 1, 1, 0);
      if (i == 98) begin
        check("up_count2_99", 32'(count2), 32'h99);
        check("up_tc2_at_99", 32'(tc2),    32'h1);
        check("up_wrap2_pre", 32'(wrap2),  32'h0);
      end
      if (i == 99) begin
        check("up_count2_wrap", 32'(count2), 32'h00);
        check("up_wrap2",       32'(wrap2),  32'h1);
        check("up_count4_100",  32'(count4), 32'h0100);
        check("up_tc2_after",   32'(tc2),    32'h0);
      end
    end

    // Down-count borrow
    step(0, 1, 16'h1000, 0, 0, 0);
    step(0, 0, 16'h0000, 1, 0, 0);
    check("borrow_count4", 32'(count4), 32'h0999);
    check("borrow_wrap4",  32'(wrap4),  32'h0);
    step(0, 1, 16'h0000, 0, 0, 0);
    check("zero_tc4", 32'(tc4), 32'h1);
    step(0, 0, 16'h0000, 1, 0, 0);
    check("under_count4", 32'(count4), 32'h9999);
    check("under_wrap4",  32'(wrap4),  32'h1);

    // Load clamp
    step(0, 1, 16'h3A7F, 0, 1, 0);
    check("clamp_count4", 32'(count4), 32'h3979);
    check("clamp_err4",   32'(err4),   32'h1);
    check("clamp_count2", 32'(count2), 32'h79);
    step(0, 0, 16'h0000, 0, 1, 0);
    check("clamp_err4_pulse", 32'(err4), 32'h0);
    step(0, 1, 16'h1234, 0, 1, 0);
    check("clean_err4",   32'(err4),   32'h0);
    check("clean_count4", 32'(count4), 32'h1234);

    // Priority
    step(1, 1, 16'h5555, 1, 1, 0);
    check("prio_rst", 32'(count4), 32'h0);
    step(0, 1, 16'h0042, 1, 1, 0);
    check("prio_load", 32'(count4), 32'h0042);

    // Saturation stimulus, sat = 1
    step(0, 1, 16'h9998, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 16'h0000, 1, 1, 1);
`ifdef BCD_CNT_SAT_EN
      check("sat_count4", 32'(count4), 32'h9999);
      check("sat_wrap4",  32'(wrap4),  32'h0);
      check("sat_tc4",    32'(tc4),    32'h1);
`else
      if (i == 1) begin
        check("nosat_count4", 32'(count4), 32'h0000);
        check("nosat_wrap4",  32'(wrap4),  32'h1);
      end
`endif
    end
    // Same with sat = 0: always wraps
    step(0, 1, 16'h9998, 0, 1, 0);
    step(0, 0, 16'h0000, 1, 1, 0);
    step(0, 0, 16'h0000, 1, 1, 0);
    check("wrap_count4", 32'(count4), 32'h0000);
    check("wrap_wrap4",  32'(wrap4),  32'h1);

    // Direction change and hold
    step(0, 1, 16'h0019, 0, 1, 0);
    step(0, 0, 16'h0000, 1, 1, 0);
    check("dir_up",   32'(count4), 32'h0020);
    step(0, 0, 16'h0000, 1, 0, 0);
    check("dir_down", 32'(count4), 32'h0019);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 16'h0000, 0, $urandom_range(0, 1) == 1, 0);
      check("hold_count4", 32'(count4), 32'h0019);
      check("hold_wrap4",  32'(wrap4),  32'h0);
    end

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 4))
        0:       lv = 16'($urandom);
        1:       lv = 16'h9999;
        2:       lv = 16'h0000;
        3:       lv = 16'h9998;
        default: lv = 16'h0001;
      endcase
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 19) == 0,
           lv,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1);
    end

    // Let the scoreboard see the last cycle.
    step(0, 0, 16'h0000, 0, 1, 0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
